// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, LSU and memory-side signals of the memory port arbiter.
// The slave modport is the arbiter's view; master is the requester/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [3:0]        lsu_be;
    logic              lsu_gnt;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
        output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
        input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between instruction fetch and the LSU and
// routes each read response back to its owner after MEM_LATENCY cycles.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic       OWN_IF     = 1'b0;
    localparam int         TAIL       = MEM_LATENCY - 1;

    logic [3:0]             starve_cnt_q;
    logic [3:0]             starve_cnt_d;
    logic [MEM_LATENCY-1:0] trk_valid_q;
    logic [MEM_LATENCY-1:0] trk_valid_d;
    logic [MEM_LATENCY-1:0] trk_owner_q;
    logic [MEM_LATENCY-1:0] trk_owner_d;
    logic [MEM_LATENCY-1:0] trk_killed_q;
    logic [MEM_LATENCY-1:0] trk_killed_d;

    logic              fetch_win_s;
    logic              if_gnt_s;
    logic              lsu_gnt_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [3:0]        mem_be_s;

    // Grant arbitration: LSU by default, fetch once it has starved long enough.
    always_comb begin
        fetch_win_s = bus.if_req && (!bus.lsu_req || (starve_cnt_q == STARVE_MAX));
        if_gnt_s    = !rst && fetch_win_s;
        lsu_gnt_s   = !rst && bus.lsu_req && !fetch_win_s;
    end

    // Starvation counter next state.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.if_req || if_gnt_s) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Memory request mux; fetch and idle cycles present a full-word read.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = bus.if_addr;
        mem_wdata_s = bus.lsu_wdata;
        mem_be_s    = 4'hF;
        if (lsu_gnt_s) begin
            mem_we_s   = bus.lsu_we;
            mem_addr_s = bus.lsu_addr;
            mem_be_s   = bus.lsu_be;
        end else begin
            mem_we_s   = 1'b0;
            mem_addr_s = bus.if_addr;
            mem_be_s   = 4'hF;
        end
    end

    // Response tracker shift; a flush marks every fetch entry still to reach the tail.
    // The entry sitting at the tail this cycle is already being delivered and is not recalled.
    always_comb begin
        trk_valid_d     = '0;
        trk_owner_d     = '0;
        trk_killed_d    = '0;
        trk_valid_d[0]  = if_gnt_s || (lsu_gnt_s && !bus.lsu_we);
        trk_owner_d[0]  = lsu_gnt_s;
        trk_killed_d[0] = bus.if_flush && if_gnt_s;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            trk_valid_d[i]  = trk_valid_q[i-1];
            trk_owner_d[i]  = trk_owner_q[i-1];
            trk_killed_d[i] = trk_killed_q[i-1] ||
                              (bus.if_flush && (trk_owner_q[i-1] == OWN_IF));
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            trk_valid_q  <= '0;
            trk_owner_q  <= '0;
            trk_killed_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            trk_valid_q  <= trk_valid_d;
            trk_owner_q  <= trk_owner_d;
            trk_killed_q <= trk_killed_d;
        end
    end

    assign bus.if_gnt     = if_gnt_s;
    assign bus.lsu_gnt    = lsu_gnt_s;
    assign bus.lsu_stall  = !rst && bus.lsu_req && !lsu_gnt_s;

    assign bus.mem_req    = if_gnt_s || lsu_gnt_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.mem_be     = mem_be_s;

    assign bus.if_rvalid  = !rst && trk_valid_q[TAIL] && !trk_killed_q[TAIL] &&
                            (trk_owner_q[TAIL] == OWN_IF);
    assign bus.lsu_rvalid = !rst && trk_valid_q[TAIL] && !trk_killed_q[TAIL] &&
                            (trk_owner_q[TAIL] != OWN_IF);
    assign bus.if_rdata   = bus.mem_rdata;
    assign bus.lsu_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LATENCY 1..3) share one
// stimulus stream; read responses are predicted into per-instance queues.
module tb_mem_port_arbiter;
    localparam int NI = 3;

    typedef struct {
        logic        own;
        logic [31:0] data;
        int          due;
        logic        killed;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_be;

    logic [NI-1:0] if_gnt_w;
    logic [NI-1:0] lsu_gnt_w;
    logic [NI-1:0] lsu_stall_w;
    logic [NI-1:0] mem_req_w;
    logic [NI-1:0] mem_we_w;
    logic [NI-1:0] if_rvalid_w;
    logic [NI-1:0] lsu_rvalid_w;
    logic [3:0]    mem_be_w    [NI];
    logic [31:0]   mem_addr_w  [NI];
    logic [31:0]   mem_wdata_w [NI];

    exp_t q [NI][$];
    int   cyc  = 0;
    int   nerr = 0;
    int   nchk = 0;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'd1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < NI; k++) begin : g_lat
        localparam int L = k + 1;
        mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        logic [31:0] pipe [L];
        exp_t        e;
        logic        ev_if;
        logic        ev_lsu;
        logic [31:0] d_if;
        logic [31:0] d_lsu;

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .STARVE_LIMIT(4)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.if_req    = if_req;
        assign bus.if_addr   = if_addr;
        assign bus.if_flush  = if_flush;
        assign bus.lsu_req   = lsu_req;
        assign bus.lsu_we    = lsu_we;
        assign bus.lsu_addr  = lsu_addr;
        assign bus.lsu_wdata = lsu_wdata;
        assign bus.lsu_be    = lsu_be;
        assign bus.mem_rdata = rd_fn(pipe[L-1]);

        assign if_gnt_w[k]     = bus.if_gnt;
        assign lsu_gnt_w[k]    = bus.lsu_gnt;
        assign lsu_stall_w[k]  = bus.lsu_stall;
        assign mem_req_w[k]    = bus.mem_req;
        assign mem_we_w[k]     = bus.mem_we;
        assign if_rvalid_w[k]  = bus.if_rvalid;
        assign lsu_rvalid_w[k] = bus.lsu_rvalid;
        assign mem_be_w[k]     = bus.mem_be;
        assign mem_addr_w[k]   = bus.mem_addr;
        assign mem_wdata_w[k]  = bus.mem_wdata;

        initial for (int j = 0; j < L; j++) pipe[j] = 32'd0;

        // memory model: read data appears L cycles after the address was presented
        always @(posedge clk) begin
            pipe[0] <= bus.mem_addr;
            for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
        end

        always @(negedge clk) begin
            ev_if  = 1'b0;
            ev_lsu = 1'b0;
            d_if   = 32'd0;
            d_lsu  = 32'd0;
            while (q[k].size() > 0 && q[k][0].due <= cyc) begin
                e = q[k].pop_front();
                if (!e.killed) begin
                    if (e.own) begin
                        ev_lsu = 1'b1;
                        d_lsu  = e.data;
                    end else begin
                        ev_if = 1'b1;
                        d_if  = e.data;
                    end
                end
            end
            chk($sformatf("L%0d_if_rvalid@%0d", L, cyc), {31'd0, bus.if_rvalid}, {31'd0, ev_if});
            chk($sformatf("L%0d_lsu_rvalid@%0d", L, cyc), {31'd0, bus.lsu_rvalid}, {31'd0, ev_lsu});
            if (ev_if)  chk($sformatf("L%0d_if_rdata@%0d", L, cyc), bus.if_rdata, d_if);
            if (ev_lsu) chk($sformatf("L%0d_lsu_rdata@%0d", L, cyc), bus.lsu_rdata, d_lsu);
        end
    end

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req    = 1'b0;
        if_flush  = 1'b0;
        lsu_req   = 1'b0;
        lsu_we    = 1'b0;
    endtask

    task automatic chk_gnt(input string tag, input logic ig, input logic lg, input logic st);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s_L%0d_if_gnt", tag, k + 1), {31'd0, if_gnt_w[k]}, {31'd0, ig});
            chk($sformatf("%s_L%0d_lsu_gnt", tag, k + 1), {31'd0, lsu_gnt_w[k]}, {31'd0, lg});
            chk($sformatf("%s_L%0d_stall", tag, k + 1), {31'd0, lsu_stall_w[k]}, {31'd0, st});
            chk($sformatf("%s_L%0d_mem_req", tag, k + 1), {31'd0, mem_req_w[k]}, {31'd0, ig | lg});
        end
    endtask

    task automatic push_rd(input logic own, input logic [31:0] addr);
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            e.own    = own;
            e.data   = rd_fn(addr);
            e.due    = cyc + k + 1;
            e.killed = 1'b0;
            q[k].push_back(e);
        end
    endtask

    task automatic kill_fetch();
        for (int k = 0; k < NI; k++)
            for (int j = 0; j < q[k].size(); j++)
                if (!q[k][j].own && q[k][j].due > cyc) q[k][j].killed = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic fw;
        rst       = 1'b1;
        if_addr   = 32'd0;
        lsu_addr  = 32'd0;
        lsu_wdata = 32'd0;
        lsu_be    = 4'hF;
        idle();
        if_req    = 1'b1;
        lsu_req   = 1'b1;
        #3;
        chk_gnt("in_reset", 1'b0, 1'b0, 1'b0);
        cyc_start();
        cyc_start();
        rst = 1'b0;
        idle();

        // LSU read of 0x100
        cyc_start();
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h100;
        @(negedge clk);
        chk_gnt("lsu_rd", 1'b0, 1'b1, 1'b0);
        chk("lsu_rd_addr", mem_addr_w[0], 32'h100);
        chk("lsu_rd_we", {31'd0, mem_we_w[0]}, 32'd0);
        push_rd(1'b1, 32'h100);
        cyc_start();
        idle();
        repeat (4) cyc_start();

        // contention: fetch wins only once starve_cnt reaches 4, then the count restarts
        if_req = 1'b1; if_addr = 32'h40; lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc_start();
            @(negedge clk);
            fw = (i == 4) || (i == 9);
            chk_gnt($sformatf("starve%0d", i), fw, !fw, fw);
            push_rd(!fw, fw ? 32'h40 : 32'h200);
        end
        cyc_start();
        idle();
        repeat (5) cyc_start();

        // flush kills in-flight fetch, not the LSU read
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        chk_gnt("flush_f0", 1'b1, 1'b0, 1'b0);
        chk("fetch_be", {28'd0, mem_be_w[1]}, 32'hF);
        chk("fetch_we", {31'd0, mem_we_w[1]}, 32'd0);
        chk("fetch_addr", mem_addr_w[1], 32'h80);
        push_rd(1'b0, 32'h80);
        cyc_start();
        if_req = 1'b0; lsu_req = 1'b1; lsu_addr = 32'h104; if_flush = 1'b1;
        @(negedge clk);
        chk_gnt("flush_l1", 1'b0, 1'b1, 1'b0);
        push_rd(1'b1, 32'h104);
        kill_fetch();
        cyc_start();
        lsu_req = 1'b0; if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h84;
        @(negedge clk);
        chk_gnt("post_flush", 1'b1, 1'b0, 1'b0);
        push_rd(1'b0, 32'h84);
        cyc_start();
        if_addr = 32'h88; if_flush = 1'b1;
        @(negedge clk);
        chk_gnt("flush_same", 1'b1, 1'b0, 1'b0);
        push_rd(1'b0, 32'h88);
        kill_fetch();
        cyc_start();
        idle();
        repeat (5) cyc_start();

        // LSU write: no response
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h20; lsu_wdata = 32'hCAFE_F00D; lsu_be = 4'b0011;
        @(negedge clk);
        chk_gnt("wr", 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("wr_we_L%0d", k + 1), {31'd0, mem_we_w[k]}, 32'd1);
            chk($sformatf("wr_be_L%0d", k + 1), {28'd0, mem_be_w[k]}, 32'h3);
            chk($sformatf("wr_wdata_L%0d", k + 1), mem_wdata_w[k], 32'hCAFE_F00D);
            chk($sformatf("wr_addr_L%0d", k + 1), mem_addr_w[k], 32'h20);
        end
        cyc_start();
        idle();
        lsu_be = 4'hF;
        repeat (4) cyc_start();

        // asynchronous reset with reads in flight
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h300;
        @(negedge clk);
        chk_gnt("rst_a", 1'b0, 1'b1, 1'b0);
        push_rd(1'b1, 32'h300);
        cyc_start();
        lsu_req = 1'b0; if_req = 1'b1; if_addr = 32'h304;
        @(negedge clk);
        chk_gnt("rst_b", 1'b1, 1'b0, 1'b0);
        push_rd(1'b0, 32'h304);
        cyc_start();
        lsu_req = 1'b1; lsu_addr = 32'h308; if_addr = 32'h30C;
        #1;
        chk_gnt("pre_rst", 1'b0, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk_gnt("mid_rst", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("mid_rst_if_rvalid_L%0d", k + 1), {31'd0, if_rvalid_w[k]}, 32'd0);
            chk($sformatf("mid_rst_lsu_rvalid_L%0d", k + 1), {31'd0, lsu_rvalid_w[k]}, 32'd0);
            q[k].delete();
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        idle();
        cyc_start();
        if_req = 1'b1; if_addr = 32'h310;
        @(negedge clk);
        chk_gnt("after_rst", 1'b1, 1'b0, 1'b0);
        push_rd(1'b0, 32'h310);
        cyc_start();
        idle();
        repeat (5) cyc_start();

        // back-to-back fetch burst
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc_start();
            if_req = 1'b1; if_addr = 32'(4 * i);
            @(negedge clk);
            chk_gnt($sformatf("burst%0d", i), 1'b1, 1'b0, 1'b0);
            push_rd(1'b0, 32'(4 * i));
        end
        cyc_start();
        idle();
        repeat (5) cyc_start();

        for (int k = 0; k < NI; k++)
            chk($sformatf("drain_L%0d", k + 1), q[k].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
